// File: rtl/fp_divider_param.sv
// Parametrised IEEE-754 divider (restoring radix-2, RNE, flush-to-zero); start to div_done = MAN_W+5 edges.
// div_start is accepted only in IDLE and ignored otherwise; there is no queueing and no output backpressure.
module fp_divider_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         div_start,
    input  logic [W-1:0] inputa,
    input  logic [W-1:0] inputb,
    output logic [W-1:0] div_result,
    output logic [4:0]   div_flags,
    output logic         div_done,
    output logic         div_busy
);
    localparam int N   = MAN_W + 3;
    localparam int CW  = $clog2(N);
    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EXP_W+1:0] EMAX = EW2'((1 << EXP_W) - 1);

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_INIT  = 5'b00010;
    localparam logic [4:0] S_EXE   = 5'b00100;
    localparam logic [4:0] S_ROUND = 5'b01000;
    localparam logic [4:0] S_DONE  = 5'b10000;

    logic [4:0]              state;
    logic [W-1:0]            a_reg, b_reg;
    logic [MAN_W+1:0]        rem;
    logic [N-1:0]            quo;
    logic [CW-1:0]           cnt;
    logic signed [EXP_W+1:0] exp_q;

    logic             sign_a, sign_b, res_sign;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] man_a, man_b;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [MAN_W:0]   mb;

    assign sign_a   = a_reg[W-1];
    assign sign_b   = b_reg[W-1];
    assign ea       = a_reg[W-2:MAN_W];
    assign eb       = b_reg[W-2:MAN_W];
    assign man_a    = a_reg[MAN_W-1:0];
    assign man_b    = b_reg[MAN_W-1:0];
    assign a_zero   = (ea == '0);
    assign b_zero   = (eb == '0);
    assign a_inf    = (&ea) && (man_a == '0);
    assign b_inf    = (&eb) && (man_b == '0);
    assign a_nan    = (&ea) && (man_a != '0);
    assign b_nan    = (&eb) && (man_b != '0);
    assign mb       = {1'b1, man_b};
    assign res_sign = sign_a ^ sign_b;

    logic             q_bit;
    logic [MAN_W+1:0] rem_sub;

    assign q_bit   = (rem >= {1'b0, mb});
    assign rem_sub = q_bit ? (rem - {1'b0, mb}) : rem;

    // Post-division: normalise, round to nearest even, resolve range and specials.
    logic                    norm, guard, sticky, inc, carry, ovf, unf;
    logic [MAN_W:0]          sig, sig_r;
    logic signed [EXP_W+1:0] e_fin;
    logic [W-1:0]            nxt_result;
    logic [4:0]              nxt_flags;

    always_comb begin
        norm   = ~quo[N-1];
        sig    = quo[N-1] ? quo[N-1:2] : quo[N-2:1];
        guard  = quo[N-1] ? quo[1] : quo[0];
        sticky = (quo[N-1] & quo[0]) | (|rem);
        inc    = guard & (sticky | sig[0]);
        sig_r  = sig + {{MAN_W{1'b0}}, inc};
        // sig always carries a leading one, so a cleared hidden bit after rounding means carry-out
        carry  = ~sig_r[MAN_W];
        e_fin  = exp_q - $signed({{(EXP_W+1){1'b0}}, norm}) + $signed({{(EXP_W+1){1'b0}}, carry});
        ovf    = (e_fin >= EMAX);
        unf    = (e_fin <= 0);

        nxt_result = {res_sign, e_fin[EXP_W-1:0], sig_r[MAN_W-1:0]};
        nxt_flags  = {3'b000, 1'b0, guard | sticky};
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            nxt_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            nxt_flags  = 5'b10000;
        end else if (b_zero && !a_inf) begin
            nxt_result = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            nxt_flags  = 5'b01000;
        end else if (a_inf) begin
            nxt_result = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            nxt_flags  = 5'b00000;
        end else if (a_zero || b_inf) begin
            nxt_result = {res_sign, {(W-1){1'b0}}};
            nxt_flags  = 5'b00000;
        end else if (ovf) begin
            nxt_result = {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            nxt_flags  = 5'b00101;
        end else if (unf) begin
            nxt_result = {res_sign, {(W-1){1'b0}}};
            nxt_flags  = 5'b00011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            rem        <= '0;
            quo        <= '0;
            cnt        <= '0;
            exp_q      <= '0;
            div_result <= '0;
            div_flags  <= '0;
            div_done   <= 1'b0;
        end else begin
            div_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (div_start) begin
                        a_reg <= inputa;
                        b_reg <= inputb;
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    rem   <= {1'b0, 1'b1, man_a};
                    quo   <= '0;
                    cnt   <= '0;
                    exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
                    state <= S_EXE;
                end
                S_EXE: begin
                    rem <= rem_sub << 1;
                    quo <= {quo[N-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    div_result <= nxt_result;
                    div_flags  <= nxt_flags;
                    div_done   <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign div_busy = (state != S_IDLE);

endmodule

// File: tb/tb_fp_divider_param.sv
// Directed bench for fp_divider_param: single precision table, handshake corners, and a half-precision instance.
module tb_fp_divider_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic [31:0] inputa, inputb, div_result;
    logic [4:0]  div_flags;
    logic        div_done, div_busy;

    logic        h_start;
    logic [15:0] h_a, h_b, h_result;
    logic [4:0]  h_flags;
    logic        h_done, h_busy;

    always #5 clk = ~clk;

    fp_divider_param u_dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .inputa     (inputa),
        .inputb     (inputb),
        .div_result (div_result),
        .div_flags  (div_flags),
        .div_done   (div_done),
        .div_busy   (div_busy)
    );

    fp_divider_param #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk        (clk),
        .rst        (rst),
        .div_start  (h_start),
        .inputa     (h_a),
        .inputb     (h_b),
        .div_result (h_result),
        .div_flags  (h_flags),
        .div_done   (h_done),
        .div_busy   (h_busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flags;
    } vec_t;

    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [4:0] fl, output int lat);
        @(negedge clk);
        inputa    = a;
        inputb    = b;
        div_start = 1'b1;
        @(posedge clk);
        #1 div_start = 1'b0;
        check("busy_after_start", {31'b0, div_busy}, 32'd1);
        lat = 0;
        while (!div_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = div_result;
        fl  = div_flags;
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'b0, div_done}, 32'd0);
        check("busy_back_idle", {31'b0, div_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        int          ndone;

        vecs[0]  = '{32'h447A0000, 32'h41B80000, 32'h422DE9BD, 5'b00001};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001};
        vecs[2]  = '{32'h40C00000, 32'hC0000000, 32'hC0400000, 5'b00000};
        vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000};
        vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000};
        vecs[5]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 5'b00000};
        vecs[6]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000};
        vecs[7]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101};
        vecs[8]  = '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011};
        vecs[9]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000};
        vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000};
        vecs[11] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000};
        vecs[12] = '{32'h00000001, 32'hBF800000, 32'h80000000, 5'b00000};
        vecs[13] = '{32'hBF800000, 32'h00400000, 32'hFF800000, 5'b01000};

        rst = 1'b1; div_start = 1'b0; inputa = '0; inputb = '0;
        h_start = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", div_result, 32'd0);
        check("reset_flags", {27'b0, div_flags}, 32'd0);
        check("reset_done", {31'b0, div_done}, 32'd0);
        check("reset_busy", {31'b0, div_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Consecutive entries also exercise a start exactly two cycles after div_done.
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, fl, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_flags", i), {27'b0, fl}, {27'b0, vecs[i].flags});
            check($sformatf("vec%0d_latency", i), lat, 32'd28);
        end

        // A start pulse with new operands during EXE must be ignored.
        @(negedge clk);
        inputa = 32'h447A0000; inputb = 32'h41B80000; div_start = 1'b1;
        @(posedge clk);
        #1 div_start = 1'b0;
        lat = 0;
        while (!div_done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 6) begin
                inputa = 32'h3F800000; inputb = 32'h40400000; div_start = 1'b1;
            end else begin
                div_start = 1'b0;
            end
        end
        check("ignore_start_result", div_result, 32'h422DE9BD);
        check("ignore_start_flags", {27'b0, div_flags}, 32'd1);
        check("ignore_start_latency", lat, 32'd28);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_done) ndone++;
        end
        check("ignore_start_no_second_done", ndone, 32'd0);

        // Reset mid-EXE discards the operation and clears the held result.
        @(negedge clk);
        inputa = 32'h40C00000; inputb = 32'hC0000000; div_start = 1'b1;
        @(posedge clk);
        #1 div_start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_result", div_result, 32'd0);
        check("midreset_flags", {27'b0, div_flags}, 32'd0);
        check("midreset_busy", {31'b0, div_busy}, 32'd0);
        check("midreset_done", {31'b0, div_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (div_done) ndone++;
        end
        check("midreset_no_done", ndone, 32'd0);

        // Back-to-back operations after the reset.
        run_op(32'h40C00000, 32'hC0000000, res, fl, lat);
        check("b2b_first_result", res, 32'hC0400000);
        check("b2b_first_latency", lat, 32'd28);
        run_op(32'h3F800000, 32'h40400000, res, fl, lat);
        check("b2b_second_result", res, 32'h3EAAAAAB);
        check("b2b_second_flags", {27'b0, fl}, 32'd1);

        // Half precision instance: 1/2 exact and 1/3 inexact.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            h_a = 16'h3C00;
            h_b = (k == 0) ? 16'h4000 : 16'h4200;
            h_start = 1'b1;
            @(posedge clk);
            #1 h_start = 1'b0;
            lat = 0;
            while (!h_done && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("half%0d_result", k), {16'b0, h_result}, (k == 0) ? 32'h3800 : 32'h3555);
            check($sformatf("half%0d_flags", k), {27'b0, h_flags}, (k == 0) ? 32'd0 : 32'd1);
            check($sformatf("half%0d_latency", k), lat, 32'd15);
            repeat (2) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
